// File: rtl/seq_mult.sv
// seq_mult: multi-cycle shift-add multiplier with a start/busy/done handshake.
//   Produces a 2*WIDTH-bit product over WIDTH clock cycles.
//   Optional macro MULT_SIGNED_EN compiles in two's-complement support
//   (operand magnitude before the loop, result negation at completion).
//   Without the macro every operand is unsigned and signed_mode is ignored.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   request a multiply (sampled in IDLE or DONE)
//   a, b         in   WIDTH-bit multiplicand / multiplier
//   signed_mode  in   1 = two's-complement operands (MULT_SIGNED_EN only)
//   busy         out  high while the shift-add loop runs
//   done         out  one-cycle pulse when prod holds a new result
//   prod         out  2*WIDTH-bit result, held until the next completion
module seq_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand magnitudes loaded into the shift registers on acceptance.
    logic [WIDTH-1:0]   mag_a, mag_b;
    // Accumulator plus this cycle's partial product.
    logic [PW-1:0]      sum;
    logic [PW-1:0]      final_val;

`ifdef MULT_SIGNED_EN
    logic               neg_q, neg_d;
    logic               neg_in;

    // |x| of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a  = (signed_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
        mag_b  = (signed_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;
        neg_in = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    logic               unused_signed_mode;

    assign unused_signed_mode = signed_mode;

    always_comb begin
        mag_a = a;
        mag_b = b;
    end
`endif

    // Partial-product add and final result (sign applied in the signed build).
    always_comb begin
        sum = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
`ifdef MULT_SIGNED_EN
        final_val = neg_q ? PW'(-sum) : sum;
`else
        final_val = sum;
`endif
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_CALC;
                    mcand_d  = PW'(mag_a);
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
`ifdef MULT_SIGNED_EN
                    neg_d    = neg_in;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last multiplier bit: commit the result.
                    prod_d  = final_val;
                    acc_d   = sum;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = CNT_W'(cnt_q + 1'b1);
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule
